// File: rtl/interrupt_controller_n.sv
// Parametrised interrupt aggregator: edge/level capture, sticky W1C status, enable mask,
// lowest-index source ID and a programmable hold-off gap. Define INT_SYNC_EN for 2-flop input sync.
module interrupt_controller_n #(
  parameter int unsigned NUM_SRC   = 8,
  parameter int unsigned ID_W      = 3,
  parameter int unsigned HOLDOFF_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_SRC-1:0]   IntSrc,
  input  logic [NUM_SRC-1:0]   IntEdgeMode,
  input  logic [NUM_SRC-1:0]   IntEnable,
  input  logic [NUM_SRC-1:0]   ClrIntSW,
  input  logic [HOLDOFF_W-1:0] HoldOff,
  output logic [NUM_SRC-1:0]   IntStatus,
  output logic                 IntPending,
  output logic [ID_W-1:0]      IntSrcId,
  output logic                 InterruptD
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } state_t;

  state_t               state, stateNext;
  logic [NUM_SRC-1:0]   srcSample;
  logic [NUM_SRC-1:0]   hist;
  logic [NUM_SRC-1:0]   setCond;
  logic [NUM_SRC-1:0]   active;
  logic [HOLDOFF_W-1:0] holdCnt;
  logic                 req;

`ifdef INT_SYNC_EN
  logic [NUM_SRC-1:0] syncMeta, syncOut;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= IntSrc;
      syncOut  <= syncMeta;
    end
  end

  assign srcSample = syncOut;
`else
  assign srcSample = IntSrc;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) hist <= '0;
    else       hist <= srcSample;
  end

  // Level mode ignores history; edge mode needs a 0 -> 1 transition.
  assign setCond = srcSample & ~(IntEdgeMode & hist);

  always_ff @(posedge Clk) begin
    if (Reset) IntStatus <= '0;
    else       IntStatus <= setCond | (IntStatus & ~ClrIntSW);
  end

  assign active = IntStatus & IntEnable;
  assign req    = |active;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // HoldOff is captured only when leaving ASSERT; the count runs down to 1 then releases.
  always_ff @(posedge Clk) begin
    if (Reset)
      holdCnt <= '0;
    else if (state == ASSERT && !req && HoldOff != '0)
      holdCnt <= HoldOff;
    else if (state == HOLDOFF)
      holdCnt <= holdCnt - HOLDOFF_W'(1);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req) stateNext = ASSERT;
      ASSERT:  if (!req) stateNext = (HoldOff == '0) ? IDLE : HOLDOFF;
      HOLDOFF: if (holdCnt == HOLDOFF_W'(1)) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    IntPending = (state == ASSERT);
  end

  assign InterruptD = IntPending ? 1'b0 : 1'bz;

  always_comb begin
    IntSrcId = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (active[NUM_SRC-1-i]) IntSrcId = ID_W'(NUM_SRC-1-i);
    end
  end

endmodule

// File: tb/tb_interrupt_controller_n.sv
// Self-checking bench for interrupt_controller_n: directed scenarios plus randomized
// traffic against a cycle-level reference model; latency follows INT_SYNC_EN.
module tb_interrupt_controller_n;
`ifdef INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] IntSrc = '0, IntEdgeMode = '0, IntEnable = '0, ClrIntSW = '0, HoldOff = '0;
  logic [7:0] IntStatus;
  logic       IntPending;
  logic [2:0] IntSrcId;
  wire        InterruptD;

  // Open-drain line: released reads back as 1 through the pull-up.
  pullup (InterruptD);

  int nChecks = 0;
  int nPass   = 0;

  logic [7:0] mH [3];
  logic [7:0] mStat;
  logic       mPend;
  int         mBlock;

  interrupt_controller_n #(.NUM_SRC(8), .ID_W(3), .HOLDOFF_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .IntSrc(IntSrc), .IntEdgeMode(IntEdgeMode),
    .IntEnable(IntEnable), .ClrIntSW(ClrIntSW), .HoldOff(HoldOff),
    .IntStatus(IntStatus), .IntPending(IntPending), .IntSrcId(IntSrcId),
    .InterruptD(InterruptD)
  );

  always #5 Clk = ~Clk;

  function automatic logic [2:0] lowestId(input logic [7:0] m);
    logic [7:0] below;
    if (m == 8'h00) return 3'd0;
    below = (m & (~m + 8'd1)) - 8'd1;
    return 3'($countones(below));
  endfunction

  // Advance one clock edge and update the reference model from the pre-edge inputs.
  task automatic tick();
    logic [7:0] v [4];
    logic [7:0] samp, prev, setv;
    logic       req;
    @(posedge Clk);
    if (Reset) begin
      mH[0] = '0; mH[1] = '0; mH[2] = '0;
      mStat = '0; mPend = 1'b0; mBlock = 0;
    end else begin
      v[0] = IntSrc; v[1] = mH[0]; v[2] = mH[1]; v[3] = mH[2];
      samp = v[LAT];
      prev = v[LAT+1];
      setv = samp & ~(IntEdgeMode & prev);
      req  = |(mStat & IntEnable);
      if (mPend) begin
        if (!req) begin
          mPend  = 1'b0;
          mBlock = int'(HoldOff);
        end
      end else if (mBlock != 0) begin
        mBlock--;
      end else if (req) begin
        mPend = 1'b1;
      end
      mStat = setv | (mStat & ~ClrIntSW);
      mH[2] = mH[1]; mH[1] = mH[0]; mH[0] = IntSrc;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    ticks(2);
    nChecks++; if (IntStatus !== 8'h00) $display("FAIL reset_status got=%h want=00", IntStatus); else nPass++;
    nChecks++; if (IntPending !== 1'b0) $display("FAIL reset_pending got=%b want=0", IntPending); else nPass++;
    nChecks++; if (IntSrcId !== 3'd0) $display("FAIL reset_id got=%0d want=0", IntSrcId); else nPass++;
    nChecks++; if (InterruptD !== 1'b1) $display("FAIL reset_line got=%b want=released", InterruptD); else nPass++;
    Reset = 1'b0;
    ticks(2);
  endtask

  task automatic test_edge_capture();
    IntEdgeMode = 8'h04; IntEnable = 8'h04; HoldOff = '0; IntSrc = '0;
    ticks(4);
    IntSrc[2] = 1'b1;
    ticks(LAT);
    nChecks++; if (IntStatus !== 8'h00) $display("FAIL edge_early got=%h want=00", IntStatus); else nPass++;
    tick();
    nChecks++; if (IntStatus !== 8'h04) $display("FAIL edge_status got=%h want=04", IntStatus); else nPass++;
    nChecks++; if (IntPending !== 1'b0) $display("FAIL edge_pend_early got=%b want=0", IntPending); else nPass++;
    tick();
    nChecks++; if (IntPending !== 1'b1) $display("FAIL edge_pend got=%b want=1", IntPending); else nPass++;
    nChecks++; if (InterruptD !== 1'b0) $display("FAIL edge_line got=%b want=0", InterruptD); else nPass++;
    nChecks++; if (IntSrcId !== 3'd2) $display("FAIL edge_id got=%0d want=2", IntSrcId); else nPass++;
    ClrIntSW = 8'h04; tick(); ClrIntSW = '0;
    nChecks++; if (IntStatus !== 8'h00) $display("FAIL edge_clr_status got=%h want=00", IntStatus); else nPass++;
    nChecks++; if (IntPending !== 1'b1) $display("FAIL edge_clr_pend_hold got=%b want=1", IntPending); else nPass++;
    tick();
    nChecks++; if (IntPending !== 1'b0) $display("FAIL edge_clr_pend got=%b want=0", IntPending); else nPass++;
    nChecks++; if (InterruptD !== 1'b1) $display("FAIL edge_clr_line got=%b want=released", InterruptD); else nPass++;
    IntSrc = '0;
    ticks(4);
  endtask

  task automatic test_level_clear();
    IntEdgeMode = '0; IntEnable = 8'h20; IntSrc[5] = 1'b1;
    ticks(LAT + 2);
    nChecks++; if (IntPending !== 1'b1) $display("FAIL level_pend got=%b want=1", IntPending); else nPass++;
    ClrIntSW = 8'h20; tick(); ClrIntSW = '0;
    nChecks++; if (IntStatus !== 8'h20) $display("FAIL level_clr_ineffective got=%h want=20", IntStatus); else nPass++;
    tick();
    nChecks++; if (IntPending !== 1'b1) $display("FAIL level_pend_stays got=%b want=1", IntPending); else nPass++;
    IntSrc[5] = 1'b0;
    ticks(LAT + 1);
    ClrIntSW = 8'h20; tick(); ClrIntSW = '0;
    nChecks++; if (IntStatus !== 8'h00) $display("FAIL level_clr got=%h want=00", IntStatus); else nPass++;
    tick();
    nChecks++; if (IntPending !== 1'b0) $display("FAIL level_pend_drop got=%b want=0", IntPending); else nPass++;
    ticks(2);
  endtask

  task automatic test_priority();
    IntEdgeMode = 8'hFF; IntEnable = 8'hFF; IntSrc = 8'h42;
    ticks(LAT + 1);
    IntSrc = '0;
    nChecks++; if (IntSrcId !== 3'd1) $display("FAIL prio_id got=%0d want=1", IntSrcId); else nPass++;
    tick();
    nChecks++; if (IntPending !== 1'b1) $display("FAIL prio_pend got=%b want=1", IntPending); else nPass++;
    ClrIntSW = 8'h02; tick(); ClrIntSW = '0;
    nChecks++; if (IntStatus !== 8'h40) $display("FAIL prio_status got=%h want=40", IntStatus); else nPass++;
    nChecks++; if (IntSrcId !== 3'd6) $display("FAIL prio_id6 got=%0d want=6", IntSrcId); else nPass++;
    tick();
    nChecks++; if (IntPending !== 1'b1) $display("FAIL prio_pend_stays got=%b want=1", IntPending); else nPass++;
    ClrIntSW = 8'h40; tick(); ClrIntSW = '0;
    ticks(2);
    nChecks++; if (IntPending !== 1'b0) $display("FAIL prio_pend_drop got=%b want=0", IntPending); else nPass++;
  endtask

  task automatic test_disabled_enable();
    IntEnable = '0; IntEdgeMode = 8'h01; IntSrc = 8'h01;
    ticks(LAT + 1);
    IntSrc = '0;
    nChecks++; if (IntStatus !== 8'h01) $display("FAIL dis_status got=%h want=01", IntStatus); else nPass++;
    tick();
    nChecks++; if (IntPending !== 1'b0) $display("FAIL dis_pend got=%b want=0", IntPending); else nPass++;
    IntEnable = 8'h01;
    tick();
    nChecks++; if (IntPending !== 1'b1) $display("FAIL en_pend got=%b want=1", IntPending); else nPass++;
    ClrIntSW = 8'h01; tick(); ClrIntSW = '0;
    tick();
    nChecks++; if (IntPending !== 1'b0) $display("FAIL en_pend_drop got=%b want=0", IntPending); else nPass++;
  endtask

  task automatic test_holdoff();
    int gap;
    HoldOff = 8'd5; IntEnable = 8'h01; IntEdgeMode = 8'h01; IntSrc = 8'h01;
    ticks(LAT + 2);
    IntSrc = '0;
    nChecks++; if (IntPending !== 1'b1) $display("FAIL hold_pend got=%b want=1", IntPending); else nPass++;
    ClrIntSW = 8'h01; tick(); ClrIntSW = '0;
    IntSrc = 8'h01;
    tick();
    nChecks++; if (IntPending !== 1'b0) $display("FAIL hold_fall got=%b want=0", IntPending); else nPass++;
    HoldOff = 8'd1;
    gap = 0;
    while (IntPending !== 1'b1 && gap < 20) begin
      nChecks++; if (InterruptD !== 1'b1) $display("FAIL hold_line got=%b want=released", InterruptD); else nPass++;
      tick();
      gap++;
    end
    nChecks++; if (gap !== 6) $display("FAIL hold_gap got=%0d want=6", gap); else nPass++;
    nChecks++; if (InterruptD !== 1'b0) $display("FAIL hold_reassert got=%b want=0", InterruptD); else nPass++;
    IntSrc = '0;
    ClrIntSW = 8'h01; tick(); ClrIntSW = '0;
    HoldOff = '0;
    ticks(10);
  endtask

  task automatic test_reset_mid_holdoff();
    HoldOff = 8'd20; IntEdgeMode = 8'hFF; IntEnable = 8'hFF; IntSrc = 8'hFF;
    ticks(LAT + 2);
    nChecks++; if (IntPending !== 1'b1) $display("FAIL rst_pre_pend got=%b want=1", IntPending); else nPass++;
    ClrIntSW = 8'hFF; tick(); ClrIntSW = '0;
    tick();
    IntSrc = '0;
    ticks(LAT + 1);
    IntSrc = 8'hFF;
    ticks(LAT + 1);
    nChecks++; if (IntStatus !== 8'hFF) $display("FAIL rst_pre_status got=%h want=ff", IntStatus); else nPass++;
    nChecks++; if (IntPending !== 1'b0) $display("FAIL rst_in_holdoff got=%b want=0", IntPending); else nPass++;
    Reset = 1'b1;
    tick();
    nChecks++; if (IntStatus !== 8'h00) $display("FAIL rst_mid_status got=%h want=00", IntStatus); else nPass++;
    nChecks++; if (IntPending !== 1'b0) $display("FAIL rst_mid_pend got=%b want=0", IntPending); else nPass++;
    nChecks++; if (IntSrcId !== 3'd0) $display("FAIL rst_mid_id got=%0d want=0", IntSrcId); else nPass++;
    nChecks++; if (InterruptD !== 1'b1) $display("FAIL rst_mid_line got=%b want=released", InterruptD); else nPass++;
    Reset = 1'b0;
    ticks(LAT + 1);
    nChecks++; if (IntStatus !== 8'hFF) $display("FAIL rst_release_edge got=%h want=ff", IntStatus); else nPass++;
    IntSrc = '0; Reset = 1'b1; HoldOff = '0;
    ticks(2);
    Reset = 1'b0;
    ticks(2);
  endtask

  task automatic test_random();
    logic [2:0] expId;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0)  IntSrc = 8'($urandom);
      ClrIntSW = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 15) == 0) IntEnable = 8'($urandom);
      if ($urandom_range(0, 31) == 0) IntEdgeMode = 8'($urandom);
      if ($urandom_range(0, 7) == 0)  HoldOff = 8'($urandom_range(0, 6));
      Reset = ($urandom_range(0, 99) == 0);
      tick();
      expId = lowestId(mStat & IntEnable);
      nChecks++; if (IntStatus !== mStat) $display("FAIL rand_status cyc=%0d got=%h want=%h", n, IntStatus, mStat); else nPass++;
      nChecks++; if (IntPending !== mPend) $display("FAIL rand_pend cyc=%0d got=%b want=%b", n, IntPending, mPend); else nPass++;
      nChecks++; if (IntSrcId !== expId) $display("FAIL rand_id cyc=%0d got=%0d want=%0d", n, IntSrcId, expId); else nPass++;
      nChecks++; if (InterruptD !== !mPend) $display("FAIL rand_line cyc=%0d got=%b want=%b", n, InterruptD, !mPend); else nPass++;
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_capture();
    test_level_clear();
    test_priority();
    test_disabled_enable();
    test_holdoff();
    test_reset_mid_holdoff();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
